// File: rtl/instruction_decoder.sv
// Decode stage for the 8-bit microprocessor: combinational instruction decode
// plus the sequencer reset synchroniser, zero flag and two-step jump nibble flag.
module instruction_decoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] pm_data,
    input  logic       alu_zero,
    output logic       sync_reset,
    output logic [7:0] ir,
    output logic       jmp,
    output logic       jmp_nz,
    output logic       dont_jmp,
    output logic       jump_flag,
    output logic [3:0] jmp_addr,
    output logic [7:0] dst_ld,
    output logic [2:0] src_sel,
    output logic       use_imm,
    output logic [3:0] imm,
    output logic       alu_en,
    output logic [2:0] alu_func
);

    typedef struct packed {
        logic       jmp;
        logic       jmp_nz;
        logic [3:0] jmp_addr;
        logic [7:0] dst_ld;
        logic [2:0] src_sel;
        logic       use_imm;
        logic [3:0] imm;
        logic       alu_en;
        logic [2:0] alu_func;
    } ctrl_t;

    logic [SYNC_STAGES-1:0] rst_sync;
    ctrl_t                  dec;

    // Asserts asynchronously, releases only after SYNC_STAGES clean edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '1;
        else          rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b0};
    end

    assign sync_reset = rst_sync[SYNC_STAGES-1];

    always_comb begin
        dec = '0;
        if (!sync_reset) begin
            if (!pm_data[7]) begin
                dec.dst_ld  = 8'b1 << pm_data[6:4];
                dec.use_imm = 1'b1;
                dec.imm     = pm_data[3:0];
            end else if (!pm_data[6]) begin
                dec.src_sel = pm_data[2:0];
                // A move onto itself is the NOP encoding.
                if (pm_data[5:3] != pm_data[2:0])
                    dec.dst_ld = 8'b1 << pm_data[5:3];
            end else if (!pm_data[5]) begin
                dec.alu_en   = 1'b1;
                dec.alu_func = pm_data[4:2];
            end else begin
                dec.jmp_addr = pm_data[3:0];
                dec.jmp      = ~pm_data[4];
                dec.jmp_nz   = pm_data[4];
            end
        end
    end

    assign jmp      = dec.jmp;
    assign jmp_nz   = dec.jmp_nz;
    assign jmp_addr = dec.jmp_addr;
    assign dst_ld   = dec.dst_ld;
    assign src_sel  = dec.src_sel;
    assign use_imm  = dec.use_imm;
    assign imm      = dec.imm;
    assign alu_en   = dec.alu_en;
    assign alu_func = dec.alu_func;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir        <= 8'h00;
            dont_jmp  <= 1'b0;
            jump_flag <= 1'b0;
        end else begin
            ir <= pm_data;
            if (sync_reset) begin
                dont_jmp  <= 1'b0;
                jump_flag <= 1'b0;
            end else begin
                if (alu_en)         dont_jmp  <= alu_zero;
                if (jmp || jmp_nz)  jump_flag <= ~jump_flag;
            end
        end
    end

endmodule

// File: doc/instruction_decoder.md
Name: instruction_decoder

Overview:
Decode stage for the 8-bit microprocessor. It consumes the instruction word returned from program memory at pm_addr and drives the program sequencer's control inputs: sync_reset, jmp, jmp_nz, dont_jmp, jump_flag and jmp_addr. It also drives the datapath register-load, source-select and ALU controls. It owns the sequencer's reset synchroniser, the zero flag and the two-step jump nibble flag.

Parameters:
SYNC_STAGES, 2, number of flops in the reset-release synchroniser (≥2)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
pm_data  in  8  instruction word from program memory
alu_zero  in  1  ALU result-is-zero, valid in the cycle alu_en=1
sync_reset  out  1  synchronised active-high reset to program sequencer
ir  out  8  registered copy of pm_data (debug)
jmp  out  1  unconditional jump request
jmp_nz  out  1  jump-if-not-zero request
dont_jmp  out  1  registered zero flag; 1 suppresses jmp_nz
jump_flag  out  1  0: jmp_addr is the address MSB nibble; 1: the LSB nibble
jmp_addr  out  4  jump nibble (pm_data[3:0])
dst_ld  out  8  one-hot register load enable
src_sel  out  3  move source register select
use_imm  out  1  1: load data is imm
imm  out  4  immediate value (pm_data[3:0])
alu_en  out  1  ALU instruction active
alu_func  out  3  ALU function (pm_data[4:2])

Behaviour:
- Reset synchroniser:
  - reset_n low asynchronously sets all SYNC_STAGES flops to 1, so sync_reset=1 immediately.
  - On release, 0 shifts in; sync_reset falls on the SYNC_STAGES-th rising clk after reset_n rises.
- Reset values (reset_n low): sync_reset=1, ir=8'h00, dont_jmp=0, jump_flag=0.
  - Combinational outputs are also forced to their gated values: all enables and requests 0; jmp_addr, imm, src_sel, alu_func = 0.
- While sync_reset=1 (including the release window):
  - jmp, jmp_nz, alu_en, use_imm = 0; dst_ld = 0.
  - jump_flag held at 0; dont_jmp held at 0.
  - ir still samples pm_data.
- Decode is combinational on pm_data; zero latency. Fields:
  - 0ddd_nnnn LOAD: dst_ld[ddd]=1, use_imm=1, imm=nnnn.
  - 10dd_dsss MOV: dst_ld[ddd]=1, src_sel=sss, use_imm=0. If ddd==sss the instruction is a NOP: dst_ld=0.
  - 110f_ffxx ALU: alu_en=1, alu_func=fff; bits [1:0] ignored.
  - 1110_nnnn JMP: jmp=1, jmp_addr=nnnn.
  - 1111_nnnn JNZ: jmp_nz=1, jmp_addr=nnnn.
  - Exactly one class is active per cycle. Outputs not used by a class are 0.
- Zero flag:
  - On a clk edge with alu_en=1: dont_jmp <= alu_zero. Otherwise it holds.
  - A JNZ in the cycle immediately after an ALU instruction sees the updated flag.
- jump_flag:
  - Toggles on every clk edge where jmp=1 or jmp_nz=1, regardless of dont_jmp.
  - A full 8-bit jump is two consecutive jump instructions: the first supplies the MSB nibble (flag 0), the second the LSB nibble (flag 1).
  - Non-jump instructions do not change the flag.
- ir <= pm_data on every edge; it has no functional use.
- Reset mid-operation: reset_n low returns all state to reset values asynchronously, regardless of the current instruction or a pending half-jump.

Test Plan:
- Reset/release: hold reset_n=0 with pm_data=8'hE5.
  - Required: sync_reset=1, jmp=0, jump_flag=0.
  - Release reset_n: sync_reset falls exactly 2 clks later; from that cycle jmp=1, jmp_addr=4'h5.
- LOAD and MOV:
  - pm_data=8'h3A -> dst_ld=8'h08, use_imm=1, imm=4'hA.
  - pm_data=8'h8B (MOV r1<-r3) -> dst_ld=8'h02, src_sel=3'd3, use_imm=0.
  - pm_data=8'h89 (r1<-r1) -> dst_ld=8'h00.
- Zero flag into JNZ:
  - ALU 8'hD4 with alu_zero=1, then 8'hF7 -> next cycle jmp_nz=1, dont_jmp=1.
  - Repeat with alu_zero=0 -> dont_jmp=0.
- Two-step jump: consecutive 8'hE3, 8'hEC.
  - Cycle 1: jump_flag=0, jmp_addr=3. Cycle 2: jump_flag=1, jmp_addr=C. After that: jump_flag=0.
  - An intervening 8'h12 leaves jump_flag unchanged.
- Mid-operation reset: pulse reset_n low for half a clk right after 8'hE3 (jump_flag=1) with dont_jmp=1.
  - Required: immediately jump_flag=0, dont_jmp=0, sync_reset=1.
  - sync_reset stays high for 2 clks after release.
